// File: rtl/register_file.sv
// register_file: 32x32 MIPS register file, two async read ports, one negedge write port, r0 hardwired to zero
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] rs,
    input  logic [ADDR_WIDTH-1:0] rt,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic                  write,
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] B
);
    localparam int N = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [1:N-1];

    // falling-edge commit so first-half writes are visible in the second half; reset beats write
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < N; i++) regs[i] <= '0;
        end else if (write && rd != '0) begin
            regs[rd] <= in;
        end
    end

    // purely combinational reads, r0 reads as zero
    always_comb begin
        A = (rs == '0) ? '0 : regs[rs];
        B = (rt == '0) ? '0 : regs[rt];
    end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed self-checking bench for register_file
module tb_register_file;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs, rt, rd;
    logic [31:0] in;
    logic        write;
    logic [31:0] A, B;
    int          checks = 0;
    int          errors = 0;

    register_file dut (
        .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .rd(rd),
        .in(in), .write(write), .A(A), .B(B)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // drive at a rising edge, release at the next one: spans exactly one falling edge
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk);
        rd = a; in = d; write = 1'b1;
        @(posedge clk);
        write = 1'b0;
    endtask

    task automatic rd2(input logic [4:0] a, input logic [4:0] b);
        rs = a; rt = b;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; write = 1'b0; rs = '0; rt = '0; rd = '0; in = '0;
        repeat (2) @(posedge clk);
        rst_n = 1'b1;

        rd2(5'd10, 5'd10);
        check("reset_a10", A, 32'h0);
        check("reset_b10", B, 32'h0);

        wr(5'd0, 32'd11);
        rd2(5'd0, 5'd0);
        check("r0_write_ignored", A, 32'h0);

        wr(5'd2, 32'd22);
        wr(5'd3, 32'd33);
        wr(5'd5, 32'd44);
        rd2(5'd0, 5'd2);
        check("a_r0", A, 32'h0);
        check("b_r2", B, 32'd22);
        rd2(5'd3, 5'd5);
        check("a_r3", A, 32'd33);
        check("b_r5", B, 32'd44);

        wr(5'd31, 32'hFFFF_FFFF);
        rd2(5'd31, 5'd1);
        check("a_r31", A, 32'hFFFF_FFFF);
        check("b_r1_untouched", B, 32'h0);

        @(posedge clk);
        rd = 5'd2; in = 32'd77; write = 1'b0;
        @(posedge clk);
        rd2(5'd2, 5'd2);
        check("no_write_en", A, 32'd22);

        @(negedge clk);
        #1 rd = 5'd7; in = 32'hDEAD_BEEF; write = 1'b1;
        #2 write = 1'b0;
        repeat (2) @(negedge clk);
        #1 rd2(5'd7, 5'd7);
        check("pulse_between_edges", A, 32'h0);

        @(posedge clk);
        rs = 5'd4; rt = 5'd4; rd = 5'd4; in = 32'h1234_5678; write = 1'b1;
        #1;
        check("rdw_a_before", A, 32'h0);
        check("rdw_b_before", B, 32'h0);
        @(negedge clk);
        #1;
        check("rdw_a_after", A, 32'h1234_5678);
        check("rdw_b_after", B, 32'h1234_5678);
        @(posedge clk);
        write = 1'b0;

        rd2(5'd2, 5'd3);
        check("pre_rst_r2", A, 32'd22);
        check("pre_rst_r3", B, 32'd33);

        @(posedge clk);
        rst_n = 1'b0; write = 1'b1; rd = 5'd2; in = 32'd99;
        @(posedge clk);
        rst_n = 1'b1; write = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd2(i[4:0], 5'(31 - i));
            check($sformatf("post_rst_a%0d", i), A, 32'h0);
            check($sformatf("post_rst_b%0d", 31 - i), B, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected done");
        $fatal(1);
    end
endmodule
